// File: rtl/kgp_isa_pkg.sv
// KGPminiRISC ISA constants shared by the fetch/branch sequencer and its jump resolver.
package kgp_isa_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OFF_W   = 26;

    localparam logic [5:0] OP_BLTZ = 6'b000111;
    localparam logic [5:0] OP_BZ   = 6'b001000;
    localparam logic [5:0] OP_BNZ  = 6'b001001;
    localparam logic [5:0] OP_BR   = 6'b001010;
    localparam logic [5:0] OP_BL   = 6'b001011;
    localparam logic [5:0] OP_BCY  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC   = 3'd1;
    localparam logic [2:0] ST_ISSUE_ENC   = 3'd2;
    localparam logic [2:0] ST_EXEC_ENC    = 3'd3;
    localparam logic [2:0] ST_RESOLVE_ENC = 3'd4;
    localparam logic [2:0] ST_HALT_ENC    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE_ENC,
        S_FETCH   = ST_FETCH_ENC,
        S_ISSUE   = ST_ISSUE_ENC,
        S_EXEC    = ST_EXEC_ENC,
        S_RESOLVE = ST_RESOLVE_ENC,
        S_HALT    = ST_HALT_ENC
    } state_t;

    function automatic logic is_branch(input logic [5:0] op);
        case (op)
            OP_BLTZ, OP_BZ, OP_BNZ, OP_BR, OP_BL, OP_BCY, OP_BNCY: is_branch = 1'b1;
            default:                                               is_branch = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jump_control.sv
// Branch condition resolver: maps opcode plus registered flags to validJump.
// Purely combinational; no handshake.
module jump_control
    import kgp_isa_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       sign,
    input  logic       carry,
    input  logic       zero,
    output logic       validJump
);

    always_comb begin
        validJump = 1'b0;
        case (opcode)
            OP_BLTZ:      validJump = sign;
            OP_BZ:        validJump = zero;
            OP_BNZ:       validJump = ~zero;
            OP_BR, OP_BL: validJump = 1'b1;
            OP_BCY:       validJump = carry;
            OP_BNCY:      validJump = ~carry;
            default:      validJump = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue/execute/resolve controller owning the PC; >=4 cycles per instruction, stalls on imem_ack and ex_done.
// Define PC_SEQ_BRANCH_STATS_EN to add saturating branch_cnt/taken_cnt outputs.
module pc_sequencer
    import kgp_isa_pkg::*;
#(
    parameter int                    PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = OP_HALT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                ex_done,
    input  logic                flag_we,
    input  logic                alu_sign,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic [PC_WIDTH-1:0] pc,
    output logic                link_we,
    output logic [PC_WIDTH-1:0] link_data,
`ifdef PC_SEQ_BRANCH_STATS_EN
    output logic [15:0]         taken_cnt,
    output logic [15:0]         branch_cnt,
`endif
    output logic                halted
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [2:0]          flags_q, flags_d;  // {sign, carry, zero}

    logic [5:0]          opcode;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] off_ext;
    logic                valid_jump;

    assign opcode  = instr_q[OPC_MSB:OPC_LSB];
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign off_ext = {{(PC_WIDTH-OFF_W){instr_q[OFF_W-1]}}, instr_q[OFF_W-1:0]};

    jump_control u_jump_control (
        .opcode    (opcode),
        .sign      (flags_q[2]),
        .carry     (flags_q[1]),
        .zero      (flags_q[0]),
        .validJump (valid_jump)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        flags_d     = flags_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        link_we     = 1'b0;
        link_data   = '0;
        halted      = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                if (ex_done) begin
                    if (flag_we) begin
                        flags_d = {alu_sign, alu_carry, alu_zero};
                    end
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                // Link is written even when HALT_OPCODE is remapped onto bl.
                if (opcode == OP_BL) begin
                    link_we   = 1'b1;
                    link_data = pc_inc;
                end
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = valid_jump ? (pc_inc + off_ext) : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;

`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [15:0] taken_q, branch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q  <= '0;
            branch_q <= '0;
        end else if (state_q == S_RESOLVE) begin
            if (is_branch(opcode) && (branch_q != 16'hFFFF)) begin
                branch_q <= branch_q + 16'd1;
            end
            if (valid_jump && (taken_q != 16'hFFFF)) begin
                taken_q <= taken_q + 16'd1;
            end
        end
    end

    assign taken_cnt  = taken_q;
    assign branch_cnt = branch_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/branch controller for the KGPminiRISC core. Owns the PC and drives the instruction-memory request/acknowledge handshake. Hands each instruction to the datapath and waits for execute completion, keeping a flag register from ALU results. Resolves branches through an instance of jump_control (opcode, sign, carry, zero → validJump), then selects the next PC.

Parameters:
PC_WIDTH, 32, width of PC and imem_addr (word-addressed)
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 6'b111111, opcode that parks the sequencer in HALT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  PC_WIDTH  fetch address (equals pc)
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
instr  output  32  latched current instruction
instr_valid  output  1  one-cycle pulse: instr issued to datapath
ex_done  input  1  datapath finished executing instr
flag_we  input  1  with ex_done: load flags from alu_*
alu_sign  input  1  ALU sign result
alu_carry  input  1  ALU carry result
alu_zero  input  1  ALU zero result
pc  output  PC_WIDTH  current PC
link_we  output  1  one-cycle pulse: write link register
link_data  output  PC_WIDTH  return address (pc+1)
halted  output  1  high while in HALT

Behaviour:
- States: IDLE, FETCH, ISSUE, EXEC, RESOLVE, HALT. IDLE lasts one cycle after rst deasserts.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, flags {s,c,z}=0. All outputs 0 except pc and imem_addr (RESET_PC).
- FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack. An ack in the first request cycle is accepted (zero wait). On ack, instr<=imem_rdata, go to ISSUE. imem_ack outside FETCH is ignored.
- ISSUE: instr_valid=1 for exactly one cycle, then go to EXEC.
- EXEC: wait for ex_done; ex_done is sampled only in EXEC. If ex_done && flag_we, flags<=alu_{sign,carry,zero}. Go to RESOLVE.
- Branch instructions still pass through EXEC. The datapath asserts ex_done with flag_we=0, so branches see the flags from the last flag-writing instruction.
- RESOLVE: drive jump_control with instr[31:26] and the registered flags.
  - If validJump: pc <= pc + 1 + sext(instr[25:0]).
  - Otherwise: pc <= pc + 1.
  - Opcode 001011 (bl) pulses link_we with link_data=pc+1. This is unconditional.
  - If opcode==HALT_OPCODE: pc is unchanged, go to HALT. Otherwise go to FETCH.
- Branch opcodes: 000111 bltz (sign), 001000 bz (zero), 001001 bnz (!zero), 001010 br (always), 001011 bl (always), 001101 bcy (carry), 001110 bncy (!carry). Any other opcode means validJump=0.
- PC arithmetic is modulo 2^PC_WIDTH. The offset is sign-extended to PC_WIDTH, and wrap-around is silent.
- HALT: halted=1, imem_req=0. Only rst exits HALT.
- rst asserted in any state, including mid-fetch, returns to the reset values immediately (async); the outstanding imem request is dropped.
- Minimum latency per instruction: FETCH(1) + ISSUE(1) + EXEC(1) + RESOLVE(1) = 4 cycles.

Optional Feature:
PC_SEQ_BRANCH_STATS_EN
- Defined: adds output taken_cnt[15:0] and output branch_cnt[15:0].
  - branch_cnt increments in RESOLVE for every branch opcode.
  - taken_cnt increments when validJump=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Shared package/header kgp_isa_pkg holds:
  - opcode constants (OP_BLTZ, OP_BZ, OP_BNZ, OP_BR, OP_BL, OP_BCY, OP_BNCY, OP_HALT);
  - state encoding localparams;
  - field positions OPC_MSB=31, OPC_LSB=26, OFF_W=26.
- Sub-module: the existing jump_control, instantiated once. Next-PC and FSM logic stay inline.

Test Plan:
- Reset release with RESET_PC=0, imem_ack one cycle after req: imem_addr=0, instr_valid pulses in cycle 3, pc=1 after RESOLVE.
- ALU op with flag_we=1, alu_zero=1, then bz offset 26'h000004 at pc=5 → pc=10. Same with zero=0 → pc=6.
- bl at pc=20 with offset 26'h3FFFFFF (-1) → link_we pulse, link_data=21, pc=20.
- bcy, then bncy at pc=0, carry=1 → bcy taken to pc=1+off; bncy not taken to pc+1.
- imem_ack delayed 3 cycles → imem_req and imem_addr stable throughout. rst asserted in the 2nd wait cycle → imem_req=0 immediately, pc=RESET_PC.
- HALT_OPCODE fetched → halted=1, pc frozen, no imem_req for 20 cycles. With PC_SEQ_BRANCH_STATS_EN defined, 3 branches / 2 taken → branch_cnt=3, taken_cnt=2.
